// File: rtl/chdr_arb_pkg.sv
// -----------------------------------------------------------------------------
// chdr_arb_pkg
// Shared definitions for the CHDR packet round-robin arbiter:
//   arb_state_t : arbiter FSM encoding (IDLE waits for a grant, PASS forwards
//                 the granted packet)
//   CNT_W       : width of each per-port completed-packet counter
//   rr_wrap     : modulo helper for round-robin index arithmetic
// -----------------------------------------------------------------------------
package chdr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_t;

  localparam int CNT_W = 32;

  // Folds an index in [0, 2*n-1] back into [0, n-1]. Round-robin candidates
  // are formed as last+offset with last < n and offset <= n, so a single
  // conditional subtraction is enough and no divider is inferred.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// -----------------------------------------------------------------------------
// rr_priority_sel
// Round-robin priority search. Starting one position above `last` and wrapping
// around, returns the first asserted bit of `req`. `last` itself is searched
// last, so a port that just won has the lowest priority next time.
//
// Ports
//   req   [N-1:0]          request vector, one bit per requester
//   last  [$clog2(N)-1:0]  index of the most recent grant
//   valid                  at least one request is asserted
//   idx   [$clog2(N)-1:0]  selected requester (0 when valid is low)
// -----------------------------------------------------------------------------
import chdr_arb_pkg::*;

module rr_priority_sel #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset 1 is the highest priority; the first hit latches and later
    // (lower priority) candidates are ignored through the !valid guard.
    for (int off = 1; off <= N; off++) begin
      cand = IDX_W'(rr_wrap(int'(last) + off, N));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/chdr_pkt_rr_arb.sv
// -----------------------------------------------------------------------------
// chdr_pkt_rr_arb
// Packet-granular round-robin arbiter merging NUM_PORTS CHDR AXI-Stream inputs
// onto one output. A grant is held from the first beat until the tlast beat
// is accepted; no data is buffered, the granted input is routed through
// combinationally. Every packet is followed by exactly one IDLE cycle in
// which the next grant is chosen.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. tvalid never depends on tready; the arbiter's tready toward the
// granted input is m_rfnoc_chdr_tready, and every other input sees tready=0.
//
// Ports
//   rfnoc_chdr_clk, rfnoc_chdr_rst_n  clock, synchronous active-low reset
//   s_rfnoc_chdr_t*                   flattened inputs, port i in slice i
//   m_rfnoc_chdr_t*                   merged output
//   arb_en                            new grants permitted while high
//   cnt_clear                         one-cycle pulse zeroing all pkt_cnt
//   grant_idx                         current or most recent grant
//   busy                              high while a packet is being passed
//   pkt_cnt                           per-port completed packets, 32 bits each
//   fsm_state                         arbiter state, for observation
// -----------------------------------------------------------------------------
import chdr_arb_pkg::*;

module chdr_pkt_rr_arb #(
  parameter int NUM_PORTS = 2,
  parameter int CHDR_W    = 64
) (
  input  logic                          rfnoc_chdr_clk,
  input  logic                          rfnoc_chdr_rst_n,
  input  logic [NUM_PORTS*CHDR_W-1:0]   s_rfnoc_chdr_tdata,
  input  logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tlast,
  input  logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tvalid,
  output logic [NUM_PORTS-1:0]          s_rfnoc_chdr_tready,
  output logic [CHDR_W-1:0]             m_rfnoc_chdr_tdata,
  output logic                          m_rfnoc_chdr_tlast,
  output logic                          m_rfnoc_chdr_tvalid,
  input  logic                          m_rfnoc_chdr_tready,
  input  logic                          arb_en,
  input  logic                          cnt_clear,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
  output logic                          busy,
  output logic [NUM_PORTS*CNT_W-1:0]    pkt_cnt,
  output arb_state_t                    fsm_state
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // Reset value of the grant register: makes port 0 the first winner.
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  arb_state_t       state_q;
  logic [IDX_W-1:0] grant_q;
  logic             busy_q;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             pkt_end;

  // ---------------------------------------------------------------------------
  // Round-robin search. grant_q doubles as the "last grant" pointer.
  // ---------------------------------------------------------------------------
  rr_priority_sel #(
    .N (NUM_PORTS)
  ) u_sel (
    .req   (s_rfnoc_chdr_tvalid),
    .last  (grant_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // ---------------------------------------------------------------------------
  // Datapath: only in PASS is the granted input connected to the output.
  // In IDLE the output is quiet and no input is acknowledged.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_rfnoc_chdr_tdata  = '0;
    m_rfnoc_chdr_tlast  = 1'b0;
    m_rfnoc_chdr_tvalid = 1'b0;
    s_rfnoc_chdr_tready = '0;
    if (state_q == ST_PASS) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_q == IDX_W'(i)) begin
          m_rfnoc_chdr_tdata     = s_rfnoc_chdr_tdata[i*CHDR_W +: CHDR_W];
          m_rfnoc_chdr_tlast     = s_rfnoc_chdr_tlast[i];
          m_rfnoc_chdr_tvalid    = s_rfnoc_chdr_tvalid[i];
          s_rfnoc_chdr_tready[i] = m_rfnoc_chdr_tready;
        end
      end
    end
  end

  // Final beat of the granted packet accepted downstream. m_tvalid is already
  // qualified by PASS, so this cannot fire in IDLE.
  assign pkt_end = m_rfnoc_chdr_tvalid & m_rfnoc_chdr_tready & m_rfnoc_chdr_tlast;

  // ---------------------------------------------------------------------------
  // Arbiter FSM. The grant only changes in IDLE, so neither arb_en, other
  // requesters nor downstream stalls can break a packet in two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge rfnoc_chdr_clk) begin
    if (!rfnoc_chdr_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= LAST_PORT;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_en && sel_valid) begin
            grant_q <= sel_idx;
            state_q <= ST_PASS;
            busy_q  <= 1'b1;
          end
        end
        ST_PASS: begin
          if (pkt_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_idx = grant_q;
  assign busy      = busy_q;
  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Per-port completed-packet counters. Free-running 32-bit wrap; a clear
  // on the same cycle as an increment leaves the counter at zero.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             inc;

    assign inc = pkt_end && (grant_q == IDX_W'(g));

    always_ff @(posedge rfnoc_chdr_clk) begin
      if (!rfnoc_chdr_rst_n) begin
        cnt_q <= '0;
      end else if (cnt_clear) begin
        cnt_q <= '0;
      end else if (inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: doc/chdr_pkt_rr_arb.md
CHDR_PKT_RR_ARB -- requirements
Module: chdr_pkt_rr_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of CHDR input requesters (legal range 2..16).
REQ-002 SHALL have parameter CHDR_W, default 64, CHDR bus width in bits.
REQ-003 SHALL have port rfnoc_chdr_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rfnoc_chdr_rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have ports s_rfnoc_chdr_tdata/tlast/tvalid/tready  in/in/in/out  NUM_PORTS*CHDR_W / NUM_PORTS / NUM_PORTS / NUM_PORTS  flattened AXI-Stream inputs; port i occupies slice i.
REQ-006 SHALL have ports m_rfnoc_chdr_tdata/tlast/tvalid/tready  out/out/out/in  CHDR_W/1/1/1  merged AXI-Stream output.
REQ-007 SHALL have port arb_en  input  1  grants allowed when high.
REQ-008 SHALL have port cnt_clear  input  1  single-cycle pulse zeroing all packet counters.
REQ-009 SHALL have port grant_idx  output  $clog2(NUM_PORTS)  index of the current or most recent grant.
REQ-010 SHALL have port busy  output  1  high while in PASS.
REQ-011 SHALL have port pkt_cnt  output  NUM_PORTS*32  per-port count of completed output packets.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, PASS.
REQ-013 In IDLE with arb_en=1 and any s_tvalid high, SHALL grant the first valid port searching upward from (last_grant+1) mod NUM_PORTS, register grant_idx, and enter PASS on the next edge.
REQ-014 In IDLE, SHALL drive m_tvalid=0 and all s_tready=0; arbitration latency is one cycle from request visible to first beat offered.
REQ-015 In PASS, SHALL combinationally route m_tdata/m_tlast/m_tvalid from the granted port, s_tready[grant]=m_tready, and all other s_tready=0; no data buffering.
REQ-016 In PASS, on a handshake (m_tvalid & m_tready) with m_tlast=1, SHALL increment pkt_cnt[grant] and return to IDLE; exactly one IDLE bubble cycle between packets.
REQ-017 A grant SHALL hold until tlast, regardless of other requesters, arb_en, or m_tready stalls of any length.
REQ-018 arb_en deassert mid-packet SHALL let the current packet complete, then block new grants.
REQ-019 Single-beat packets (tvalid and tlast on the first beat) SHALL be passed and counted normally.
REQ-020 pkt_cnt entries SHALL be 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
REQ-021 When cnt_clear and an increment coincide, clear SHALL win; the result is 0.
REQ-022 Input tvalid deasserting mid-packet SHALL be tolerated; the grant is kept and m_tvalid follows it.
REQ-023 With NUM_PORTS ports all continuously requesting, each port SHALL receive exactly one packet per NUM_PORTS grants.

Reset
REQ-024 When rfnoc_chdr_rst_n=0 at a clock edge: FSM=IDLE; last_grant=NUM_PORTS-1 (so port 0 wins first); grant_idx=NUM_PORTS-1; busy=0; all pkt_cnt=0.
REQ-025 During and immediately after reset, m_tvalid=0 and all s_tready=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet with no count increment; the upstream source is responsible for discarding the remainder.

Structure
REQ-027 State enum (IDLE, PASS) and the counter width constant (32) SHALL reside in a shared package, chdr_arb_pkg.
REQ-028 The round-robin priority search SHALL be a sub-module, rr_priority_sel (inputs: req vector, last index; outputs: valid, index).

Verification
REQ-029 After reset, a 3-beat packet on port 1 only -> granted with grant_idx=1, first beat on output 1 cycle after tvalid; pkt_cnt[1]=1; port 0 tready stays 0.
REQ-030 Ports 0 and 1 both stream 4 packets of 5 beats each -> output packet order 0,1,0,1,...; 8 packets with no interleaved beats; both counts = 4.
REQ-031 m_tready toggled pseudo-randomly (50%) during a 201-beat packet -> output data matches input beat-for-beat; the other port is never granted mid-packet.
REQ-032 arb_en cleared on beat 2 of a 10-beat packet -> packet completes, then no further grants while requests remain pending; re-asserting arb_en resumes at the next port.
REQ-033 pkt_cnt[0] preloaded near 0xFFFFFFFF (force), then 2 packets sent -> count wraps to 0x00000000; cnt_clear pulsed on the same cycle as a tlast handshake -> pkt_cnt=0.
REQ-034 rfnoc_chdr_rst_n driven low on beat 3 of a packet -> next cycle shows IDLE, busy=0, all counts 0, and port 0 wins the next arbitration.
